bitcoin_nonce_scanner: RTL and testbench

- Parametrised successor to the single-shot two-phase SHA-256 core.
- Sweeps a range of nonces and, for each one, computes the double SHA-256 of the 80-byte header tail against a supplied midstate.
- Compares each digest to a 256-bit target and streams results out through a valid/ready handshake.
- Sits between the header/midstate loader and the result collector in the mining top level.

---
 rtl/bitcoin_nonce_scanner_if.sv | 27 ++
 rtl/bitcoin_nonce_scanner.sv | 223 ++++++++++++++++++++++
 tb/tb_bitcoin_nonce_scanner.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bitcoin_nonce_scanner_if.sv
// Loader/collector-facing bus of the nonce scanner: scan setup inputs, status and the result handshake.
// Multi-word fields are flat with word 0 (H0, T0, header word 16) in the most significant bits.
interface bitcoin_nonce_scanner_if;
  logic         start;
  logic [255:0] midstate;
  logic [95:0]  message;
  logic [31:0]  nonce_base;
  logic [255:0] target;
  logic         busy;
  logic         result_valid;
  logic         result_ready;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic         result_hit;
  logic [16:0]  hit_count;
  logic         done;

  modport master (
    output start, midstate, message, nonce_base, target, result_ready,
    input  busy, result_valid, result_nonce, result_hash, result_hit, hit_count, done
  );

  modport slave (
    input  start, midstate, message, nonce_base, target, result_ready,
    output busy, result_valid, result_nonce, result_hash, result_hit, hit_count, done
  );
endinterface

// File: rtl/bitcoin_nonce_scanner.sv
// Double SHA-256 nonce sweep, one round per cycle; first result 130 edges after start acceptance.
// Results wait in OUT until accepted (no valid->ready bypass); the sweep stalls meanwhile.
module bitcoin_nonce_scanner #(
  parameter int NUM_NONCES  = 16,
  parameter int STOP_ON_HIT = 1,
  parameter int EMIT_ALL    = 1
) (
  input logic                    clk,
  input logic                    reset_n,
  bitcoin_nonce_scanner_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RUN1, LOAD2, RUN2, FINAL, OUT, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    rnd_q, rnd_d;
  logic [16:0]   idx_q, idx_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [31:0]   mid_q [8], mid_d [8];
  logic [95:0]   msg_q, msg_d;
  logic [255:0]  tgt_q, tgt_d;
  logic [31:0]   s_q [8], s_d [8];
  logic [31:0]   w_q [16], w_d [16];
  logic          res_vld_q, res_vld_d;
  logic [31:0]   res_nonce_q, res_nonce_d;
  logic [255:0]  res_hash_q, res_hash_d;
  logic          res_hit_q, res_hit_d;
  logic [16:0]   hit_cnt_q, hit_cnt_d;

  logic [31:0]   t1, t2, w_new, ld_nonce;
  logic [255:0]  dig;
  logic [95:0]   ld_msg;
  logic [31:0]   ld_mid [8];
  logic          hit, advance, adv_hit, load1;

  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    idx_d       = idx_q;
    nonce_d     = nonce_q;
    mid_d       = mid_q;
    msg_d       = msg_q;
    tgt_d       = tgt_q;
    s_d         = s_q;
    w_d         = w_q;
    res_vld_d   = res_vld_q;
    res_nonce_d = res_nonce_q;
    res_hash_d  = res_hash_q;
    res_hit_d   = res_hit_q;
    hit_cnt_d   = hit_cnt_q;
    advance     = 1'b0;
    adv_hit     = res_hit_q;
    load1       = 1'b0;
    ld_nonce    = nonce_q + 32'd1;
    ld_msg      = msg_q;
    ld_mid      = mid_q;

    t1    = s_q[7] + bsig1(s_q[4]) + ((s_q[4] & s_q[5]) ^ (~s_q[4] & s_q[6])) + K[rnd_q] + w_q[0];
    t2    = bsig0(s_q[0]) + ((s_q[0] & s_q[1]) ^ (s_q[0] & s_q[2]) ^ (s_q[1] & s_q[2]));
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    dig   = '0;
    for (int i = 0; i < 8; i++) dig[255-32*i -: 32] = s_q[i] + IV[i];
    hit   = dig < tgt_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          for (int i = 0; i < 8; i++) ld_mid[i] = bus.midstate[255-32*i -: 32];
          ld_msg    = bus.message;
          ld_nonce  = bus.nonce_base;
          mid_d     = ld_mid;
          msg_d     = bus.message;
          tgt_d     = bus.target;
          nonce_d   = bus.nonce_base;
          idx_d     = '0;
          hit_cnt_d = '0;
          load1     = 1'b1;
        end
      end
      RUN1, RUN2: begin
        s_d[0] = t1 + t2;
        s_d[1] = s_q[0];
        s_d[2] = s_q[1];
        s_d[3] = s_q[2];
        s_d[4] = s_q[3] + t1;
        s_d[5] = s_q[4];
        s_d[6] = s_q[5];
        s_d[7] = s_q[6];
        // window holds w[t..t+15]; w[t+16] enters at the top
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new;
        rnd_d   = rnd_q + 6'd1;
        if (rnd_q == 6'd63) state_d = (state_q == RUN1) ? LOAD2 : FINAL;
      end
      LOAD2: begin
        for (int i = 0; i < 8; i++) w_d[i] = s_q[i] + mid_q[i];
        w_d[8] = 32'h80000000;
        for (int i = 9; i < 15; i++) w_d[i] = '0;
        w_d[15] = 32'd256;
        s_d     = IV;
        rnd_d   = '0;
        state_d = RUN2;
      end
      FINAL: begin
        if (hit && hit_cnt_q != 17'h10000) hit_cnt_d = hit_cnt_q + 17'd1;
        if (EMIT_ALL != 0 || hit) begin
          res_vld_d   = 1'b1;
          res_nonce_d = nonce_q;
          res_hash_d  = dig;
          res_hit_d   = hit;
          state_d     = OUT;
        end else begin
          advance = 1'b1;
          adv_hit = hit;
        end
      end
      OUT: begin
        if (bus.result_ready) begin
          res_vld_d = 1'b0;
          advance   = 1'b1;
        end
      end
      default: ;
    endcase

    if (advance) begin
      if (idx_q == 17'(NUM_NONCES - 1) || (STOP_ON_HIT != 0 && adv_hit)) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_q + 17'd1;
        nonce_d = ld_nonce;
        load1   = 1'b1;
      end
    end

    if (load1) begin
      w_d[0] = ld_msg[95:64];
      w_d[1] = ld_msg[63:32];
      w_d[2] = ld_msg[31:0];
      w_d[3] = ld_nonce;
      w_d[4] = 32'h80000000;
      for (int i = 5; i < 15; i++) w_d[i] = '0;
      w_d[15] = 32'd640;
      s_d     = ld_mid;
      rnd_d   = '0;
      state_d = RUN1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      idx_q       <= '0;
      nonce_q     <= '0;
      msg_q       <= '0;
      tgt_q       <= '0;
      res_vld_q   <= 1'b0;
      res_nonce_q <= '0;
      res_hash_q  <= '0;
      res_hit_q   <= 1'b0;
      hit_cnt_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        mid_q[i] <= '0;
        s_q[i]   <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      idx_q       <= idx_d;
      nonce_q     <= nonce_d;
      msg_q       <= msg_d;
      tgt_q       <= tgt_d;
      res_vld_q   <= res_vld_d;
      res_nonce_q <= res_nonce_d;
      res_hash_q  <= res_hash_d;
      res_hit_q   <= res_hit_d;
      hit_cnt_q   <= hit_cnt_d;
      mid_q       <= mid_d;
      s_q         <= s_d;
      w_q         <= w_d;
    end
  end

  assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
  assign bus.done         = (state_q == DONE);
  assign bus.result_valid = res_vld_q;
  assign bus.result_nonce = res_nonce_q;
  assign bus.result_hash  = res_hash_q;
  assign bus.result_hit   = res_hit_q;
  assign bus.hit_count    = hit_cnt_q;
endmodule

// File: tb/tb_bitcoin_nonce_scanner.sv
// Directed bench for bitcoin_nonce_scanner: two instances cover stop-on-hit/emit-all and sweep/hits-only setups.
// Expected digests come from a straightforward full-schedule double SHA-256 model.
module tb_bitcoin_nonce_scanner;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bitcoin_nonce_scanner_if if_a ();
  bitcoin_nonce_scanner_if if_b ();

  bitcoin_nonce_scanner #(.NUM_NONCES(4), .STOP_ON_HIT(1), .EMIT_ALL(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  bitcoin_nonce_scanner #(.NUM_NONCES(8), .STOP_ON_HIT(0), .EMIT_ALL(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IVP = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [255:0] MID_A = 256'hbc909a336358bff090ccac7d1e59caa8c3c8d8e94f0103c896b187364719f91b;
  localparam logic [95:0]  MSG_A = 96'h4b1e5e4a29ab5f49ffff001d;
  localparam logic [255:0] MID_B = 256'h0123456789abcdeffedcba9876543210deadbeefcafef00d1122334455667788;
  localparam logic [95:0]  MSG_B = 96'h13579bdf2468ace0a5a55a5a;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) v[i] = st[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = v[i] + st[255-32*i -: 32];
    return r;
  endfunction

  function automatic logic [255:0] golden(input logic [255:0] mid, input logic [95:0] msg, input logic [31:0] nonce);
    logic [255:0] h1;
    h1 = compress(mid, {msg, nonce, 32'h80000000, 320'd0, 32'd640});
    return compress(IVP, {h1, 32'h80000000, 192'd0, 32'd256});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_a(input string tag, input int budget, output int edges);
    edges = 0;
    while (if_a.result_valid !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
    chk({tag, ".valid"}, 256'(if_a.result_valid), 256'(1));
  endtask

  task automatic start_a(input logic [31:0] base, input logic [255:0] tgt);
    if_a.nonce_base = base;
    if_a.target     = tgt;
    if_a.start      = 1'b1;
    tick();
    if_a.start      = 1'b0;
  endtask

  task automatic expect_a(input string tag, input logic [31:0] nonce, input logic hit);
    int e;
    wait_a(tag, 400, e);
    chk({tag, ".nonce"}, 256'(if_a.result_nonce), 256'(nonce));
    chk({tag, ".hash"}, if_a.result_hash, golden(MID_A, MSG_A, nonce));
    chk({tag, ".hit"}, 256'(if_a.result_hit), 256'(hit));
    if_a.result_ready = 1'b1;
    tick();
    if_a.result_ready = 1'b0;
  endtask

  initial begin
    int           e, nres, done_cyc;
    logic         stable, found, ok;
    logic [31:0]  hn, base_b, n;
    logic [255:0] hh, tgt_b;
    logic [255:0] d [8];

    reset_n = 1'b0;
    if_a.start = 1'b0; if_a.result_ready = 1'b0;
    if_a.midstate = MID_A; if_a.message = MSG_A; if_a.nonce_base = '0; if_a.target = '0;
    if_b.start = 1'b0; if_b.result_ready = 1'b0;
    if_b.midstate = MID_B; if_b.message = MSG_B; if_b.nonce_base = '0; if_b.target = '0;
    repeat (3) tick();

    chk("rst.busy", 256'(if_a.busy), 256'(0));
    chk("rst.valid", 256'(if_a.result_valid), 256'(0));
    chk("rst.nonce", 256'(if_a.result_nonce), 256'(0));
    chk("rst.hash", if_a.result_hash, 256'(0));
    chk("rst.hit_count", 256'(if_a.hit_count), 256'(0));
    chk("rst.done", 256'(if_a.done), 256'(0));
    chk("rst.b_hash", if_b.result_hash, 256'(0));
    reset_n = 1'b1;
    tick();

    // model sanity: SHA-256("abc")
    chk("model.abc", compress(IVP, {32'h61626380, 448'd0, 32'h18}),
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

    // target 0: full sweep, never a hit
    start_a(32'h10, 256'd0);
    chk("A.busy", 256'(if_a.busy), 256'(1));
    wait_a("A.first", 200, e);
    chk("A.latency", 256'(e), 256'(130));
    for (int i = 0; i < 4; i++) expect_a($sformatf("A%0d", i), 32'h10 + 32'(i), 1'b0);
    chk("A.done", 256'(if_a.done), 256'(1));
    chk("A.busy_end", 256'(if_a.busy), 256'(0));
    chk("A.hit_count", 256'(if_a.hit_count), 256'(0));

    // target all ones: stop after first hit
    start_a(32'h55, '1);
    wait_a("B.first", 200, e);
    chk("B.latency", 256'(e), 256'(130));
    expect_a("B0", 32'h55, 1'b1);
    chk("B.done", 256'(if_a.done), 256'(1));
    chk("B.hit_count", 256'(if_a.hit_count), 256'(1));

    // nonce wrap
    start_a(32'hfffffffe, 256'd0);
    for (int i = 0; i < 4; i++) begin
      n = 32'hfffffffe + 32'(i);
      expect_a($sformatf("C%0d", i), n, 1'b0);
    end
    chk("C.done", 256'(if_a.done), 256'(1));

    // backpressure with inputs changed mid-scan and a start while busy
    start_a(32'h200, 256'd0);
    wait_a("D.first", 200, e);
    hn = if_a.result_nonce;
    hh = if_a.result_hash;
    if_a.midstate = ~MID_A; if_a.message = ~MSG_A; if_a.nonce_base = 32'h0; if_a.target = '1;
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if_a.start = (i == 10);
      tick();
      if (if_a.result_valid !== 1'b1 || if_a.result_nonce !== hn || if_a.result_hash !== hh) stable = 1'b0;
    end
    if_a.start = 1'b0;
    chk("D.stable", 256'(stable), 256'(1));
    expect_a("D0", 32'h200, 1'b0);
    expect_a("D1", 32'h201, 1'b0);

    // reset in the middle of the second hash of the third nonce
    repeat (100) tick();
    chk("R.busy_pre", 256'(if_a.busy), 256'(1));
    reset_n = 1'b0;
    #1;
    chk("R.busy", 256'(if_a.busy), 256'(0));
    chk("R.valid", 256'(if_a.result_valid), 256'(0));
    chk("R.hash", if_a.result_hash, 256'(0));
    chk("R.nonce", 256'(if_a.result_nonce), 256'(0));
    chk("R.done", 256'(if_a.done), 256'(0));
    tick();
    reset_n = 1'b1;
    if_a.midstate = MID_A; if_a.message = MSG_A;
    tick();
    start_a(32'h200, 256'd0);
    for (int i = 0; i < 4; i++) expect_a($sformatf("R%0d", i), 32'h200 + 32'(i), 1'b0);
    chk("R.done_end", 256'(if_a.done), 256'(1));

    // hits-only sweep: pick a base where index 2 has the smallest of eight digests
    found = 1'b0;
    base_b = '0;
    for (int k = 0; k < 64 && !found; k++) begin
      base_b = 32'h1000 + 32'(8 * k);
      for (int i = 0; i < 8; i++) d[i] = golden(MID_B, MSG_B, base_b + 32'(i));
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (i != 2 && d[i] <= d[2]) ok = 1'b0;
      found = ok;
    end
    chk("E.search", 256'(found), 256'(1));
    tgt_b = d[2] + 256'd1;
    if_b.nonce_base = base_b;
    if_b.target = tgt_b;
    if_b.result_ready = 1'b1;
    if_b.start = 1'b1;
    tick();
    if_b.start = 1'b0;
    nres = 0;
    done_cyc = -1;
    for (int c = 1; c <= 1300 && done_cyc < 0; c++) begin
      tick();
      if (if_b.result_valid === 1'b1) begin
        nres++;
        if (nres == 1) begin
          chk("E.nonce", 256'(if_b.result_nonce), 256'(base_b + 32'd2));
          chk("E.hash", if_b.result_hash, d[2]);
          chk("E.hit", 256'(if_b.result_hit), 256'(1));
        end
      end
      if (if_b.done === 1'b1) done_cyc = c;
    end
    if_b.result_ready = 1'b0;
    chk("E.results", 256'(nres), 256'(1));
    chk("E.done_cycle", 256'(done_cyc), 256'(8 * 130 + 1));
    chk("E.hit_count", 256'(if_b.hit_count), 256'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
